// File: rtl/load_writeback_unit.sv
// Registered writeback-select / load-extract stage: picks the register-file write data,
// aligns and sign/zero-extends loads, and fetches a second memory beat for crossing loads.
module load_writeback_unit #(
  parameter int XLEN        = 64,
  parameter bit MISALIGN_EN = 1'b1,
  localparam int BYTES      = XLEN / 8,
  localparam int OFFW       = $clog2(BYTES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      sel,
  input  logic [OFFW-1:0] addr_off,
  input  logic [XLEN-1:0] mem_data,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] shift_out,
  output logic            hi_req,
  input  logic            hi_valid,
  input  logic [XLEN-1:0] hi_data,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_err
);

  typedef enum logic {IDLE, HI_WAIT} state_t;

  typedef struct packed {
    logic       legal;
    logic       is_load;
    logic       sgn;
    logic [3:0] size;
  } dec_t;

  function automatic dec_t decode(input logic [3:0] s);
    dec_t d;
    d.legal   = 1'b1;
    d.is_load = 1'b1;
    d.sgn     = 1'b0;
    d.size    = 4'd0;
    case (s)
      4'b0000, 4'b0010, 4'b0011, 4'b0100, 4'b1100: d.is_load = 1'b0;
      4'b0110: begin d.size = 4'd1; d.sgn = 1'b1; end
      4'b0111: begin d.size = 4'd2; d.sgn = 1'b1; end
      4'b1000: begin d.size = 4'd4; d.sgn = 1'b1; end
      4'b1001: d.size = 4'd1;
      4'b1010: d.size = 4'd2;
      4'b0101: begin d.size = 4'd8; d.sgn = 1'b1; d.legal = (XLEN == 64); end
      4'b1011: begin d.size = 4'd4; d.legal = (XLEN == 64); end
      default: d.legal = 1'b0;
    endcase
    // Illegal codes never count as loads, so they can never start a second beat.
    if (!d.legal) d.is_load = 1'b0;
    return d;
  endfunction

  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] lo,
                                              input logic [XLEN-1:0] hi,
                                              input logic [OFFW-1:0] off,
                                              input logic            sgn,
                                              input logic [3:0]      size);
    logic [XLEN-1:0] res;
    logic            fill;
    res  = XLEN'({hi, lo} >> (8 * off));
    fill = 1'b0;
    for (int i = 0; i < BYTES; i++) begin
      if (i == int'(size) - 1) fill = sgn & res[8*i+7];
    end
    for (int i = 0; i < BYTES; i++) begin
      if (i >= int'(size)) res[8*i +: 8] = {8{fill}};
    end
    return res;
  endfunction

  state_t          state_q, state_d;
  logic            wb_valid_q, wb_valid_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            wb_err_q, wb_err_d;
  logic            hi_req_q, hi_req_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [OFFW-1:0] off_q, off_d;
  logic            sgn_q, sgn_d;
  logic [3:0]      size_q, size_d;

  dec_t dec;
  logic crossing;
  logic accept;

  assign in_ready = (state_q == IDLE) && (!wb_valid_q || wb_ready);
  assign accept   = in_valid && in_ready;
  assign hi_req   = hi_req_q;
  assign wb_valid = wb_valid_q;
  assign wb_data  = wb_data_q;
  assign wb_err   = wb_err_q;

  always_comb begin
    dec      = decode(sel);
    crossing = dec.is_load && (int'(addr_off) + int'(dec.size) > BYTES);

    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    state_d    = state_q;
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_err_d   = wb_err_q;
    hi_req_d   = 1'b0;
    lo_d       = lo_q;
    off_d      = off_q;
    sgn_d      = sgn_q;
    size_d     = size_q;

    if (wb_valid_q && wb_ready) wb_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (crossing && MISALIGN_EN) begin
            lo_d     = mem_data;
            off_d    = addr_off;
            sgn_d    = dec.sgn;
            size_d   = dec.size;
            hi_req_d = 1'b1;
            state_d  = HI_WAIT;
          end else begin
            wb_valid_d = 1'b1;
            wb_err_d   = 1'b0;
            if (!dec.legal || crossing) begin
              wb_err_d  = 1'b1;
              wb_data_d = '0;
            end else if (dec.is_load) begin
              wb_data_d = extract(mem_data, '0, addr_off, dec.sgn, dec.size);
            end else begin
              case (sel)
                4'b0000: wb_data_d = alu_out;
                4'b0010: wb_data_d = {{(XLEN-1){1'b0}}, 1'b1};
                4'b0100: wb_data_d = pc;
                4'b1100: wb_data_d = shift_out;
                default: wb_data_d = '0;
              endcase
            end
          end
        end
      end
      HI_WAIT: begin
        // wb_valid is always clear here: the slot was freed when the load was accepted.
        if (hi_valid) begin
          wb_valid_d = 1'b1;
          wb_err_d   = 1'b0;
          wb_data_d  = extract(lo_q, hi_data, off_q, sgn_q, size_q);
          state_d    = IDLE;
        end
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_err_q   <= 1'b0;
      hi_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_err_q   <= wb_err_d;
      hi_req_q   <= hi_req_d;
    end
  end

  // NOTE: the latched low beat is only read in HI_WAIT, which reset leaves, so it needs no reset.
  always_ff @(posedge clk) begin
    lo_q   <= lo_d;
    off_q  <= off_d;
    sgn_q  <= sgn_d;
    size_q <= size_d;
  end

endmodule

// File: tb/tb_load_writeback_unit.sv
// Bench for load_writeback_unit: byte-level reference model with a per-cycle compare
// process, directed corner cases, and extra instances for MISALIGN_EN=0 and XLEN=32.
module tb_load_writeback_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  // Main instance: XLEN=64, MISALIGN_EN=1
  logic        in_valid = 1'b0, hi_valid = 1'b0, wb_ready = 1'b0;
  logic        in_ready, hi_req, wb_valid, wb_err;
  logic [3:0]  sel = 4'd0;
  logic [2:0]  addr_off = 3'd0;
  logic [63:0] mem_data = '0, alu_out = '0, pc = '0, shift_out = '0, hi_data = '0;
  logic [63:0] wb_data;

  load_writeback_unit #(.XLEN(64), .MISALIGN_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
    .addr_off(addr_off), .mem_data(mem_data), .alu_out(alu_out), .pc(pc),
    .shift_out(shift_out), .hi_req(hi_req), .hi_valid(hi_valid), .hi_data(hi_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_err(wb_err));

  // Second instance: misaligned loads flagged instead of fetched
  logic        n_in_valid = 1'b0, n_wb_ready = 1'b1;
  logic        n_in_ready, n_hi_req, n_wb_valid, n_wb_err;
  logic [3:0]  n_sel = 4'd0;
  logic [2:0]  n_off = 3'd0;
  logic [63:0] n_mem = '0, n_wb_data;

  load_writeback_unit #(.XLEN(64), .MISALIGN_EN(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready), .sel(n_sel),
    .addr_off(n_off), .mem_data(n_mem), .alu_out(64'd0), .pc(64'd0),
    .shift_out(64'd0), .hi_req(n_hi_req), .hi_valid(1'b0), .hi_data(64'd0),
    .wb_valid(n_wb_valid), .wb_ready(n_wb_ready), .wb_data(n_wb_data), .wb_err(n_wb_err));

  // Third instance: 32-bit datapath
  logic        c_in_valid = 1'b0, c_wb_ready = 1'b1;
  logic        c_in_ready, c_hi_req, c_wb_valid, c_wb_err;
  logic [3:0]  c_sel = 4'd0;
  logic [1:0]  c_off = 2'd0;
  logic [31:0] c_mem = '0, c_wb_data;

  load_writeback_unit #(.XLEN(32), .MISALIGN_EN(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready), .sel(c_sel),
    .addr_off(c_off), .mem_data(c_mem), .alu_out(32'd0), .pc(32'd0),
    .shift_out(32'd0), .hi_req(c_hi_req), .hi_valid(1'b0), .hi_data(32'd0),
    .wb_valid(c_wb_valid), .wb_ready(c_wb_ready), .wb_data(c_wb_data), .wb_err(c_wb_err));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model (XLEN=64): loads read bytes off..off+size-1 of the 16-byte window.
  function automatic int ref_size(input logic [3:0] s);
    case (s)
      4'd6, 4'd9:  return 1;
      4'd7, 4'd10: return 2;
      4'd8, 4'd11: return 4;
      4'd5:        return 8;
      default:     return 0;
    endcase
  endfunction

  function automatic logic [64:0] ref_result(input logic [3:0] s, input int off,
                                             input logic [63:0] lo, input logic [63:0] hi,
                                             input logic [63:0] alu, input logic [63:0] pcv,
                                             input logic [63:0] sh);
    logic [7:0]  b [16];
    logic [63:0] v;
    int          size;
    bit          sgn;
    case (s)
      4'd0:  return {1'b0, alu};
      4'd2:  return {1'b0, 64'd1};
      4'd3:  return {1'b0, 64'd0};
      4'd4:  return {1'b0, pcv};
      4'd12: return {1'b0, sh};
      default: ;
    endcase
    size = ref_size(s);
    if (size == 0) return {1'b1, 64'd0};
    sgn = (s == 4'd5) || (s == 4'd6) || (s == 4'd7) || (s == 4'd8);
    for (int i = 0; i < 8; i++) begin
      b[i]     = lo[8*i +: 8];
      b[i + 8] = hi[8*i +: 8];
    end
    v = '0;
    for (int k = 0; k < size; k++) v[8*k +: 8] = b[off + k];
    if (sgn && size < 8 && v[8*size-1]) v = v | ~((64'd1 << (8 * size)) - 64'd1);
    return {1'b0, v};
  endfunction

  // Model state and per-cycle compare process
  logic [64:0] exp_q[$];
  bit          pending = 1'b0;
  bit          exp_hireq = 1'b0;
  bit          exp_rdy;
  logic [3:0]  p_sel;
  int          p_off;
  logic [63:0] p_lo;

  always @(negedge clk) begin
    exp_rdy = !pending && (exp_q.size() == 0 || wb_ready);
    check("wb_valid", {63'd0, wb_valid}, {63'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      check("wb_data", wb_data, exp_q[0][63:0]);
      check("wb_err", {63'd0, wb_err}, {63'd0, exp_q[0][64]});
    end
    check("hi_req", {63'd0, hi_req}, {63'd0, exp_hireq});
    check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    exp_hireq = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      pending = 1'b0;
    end else begin
      if (exp_q.size() != 0 && wb_ready) void'(exp_q.pop_front());
      if (pending) begin
        if (hi_valid) begin
          exp_q.push_back(ref_result(p_sel, p_off, p_lo, hi_data, '0, '0, '0));
          pending = 1'b0;
        end
      end else if (in_valid && exp_rdy) begin
        if (ref_size(sel) != 0 && int'(addr_off) + ref_size(sel) > 8) begin
          pending   = 1'b1;
          p_sel     = sel;
          p_off     = int'(addr_off);
          p_lo      = mem_data;
          exp_hireq = 1'b1;
        end else begin
          exp_q.push_back(ref_result(sel, int'(addr_off), mem_data, 64'd0, alu_out, pc, shift_out));
        end
      end
    end
  end

  logic [64:0] m;
  logic [63:0] v_shift, v_alu;

  initial begin
    // Pin the model against hand-computed values
    m = ref_result(4'd6, 3, 64'h0000_0000_8000_0000, 64'd0, '0, '0, '0);
    check("model_lb", m[63:0], 64'hFFFF_FFFF_FFFF_FF80);
    m = ref_result(4'd10, 7, 64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00CD, '0, '0, '0);
    check("model_lhu_cross", m[63:0], 64'h0000_0000_0000_CDAB);
    m = ref_result(4'd8, 4, 64'h8765_4321_0000_0000, 64'd0, '0, '0, '0);
    check("model_lw", m[63:0], 64'hFFFF_FFFF_8765_4321);
    m = ref_result(4'd15, 0, 64'd1, 64'd0, '0, '0, '0);
    check("model_illegal", {63'd0, m[64]}, 64'd1);

    repeat (2) tick();
    check("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    check("rst_wb_data", wb_data, 64'd0);
    check("rst_hi_req", {63'd0, hi_req}, 64'd0);
    rst_n = 1'b1;

    // Sign-extended byte load at offset 3
    in_valid = 1'b1; sel = 4'b0110; addr_off = 3'd3; mem_data = 64'h0000_0000_8000_0000;
    wb_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("lb_valid", {63'd0, wb_valid}, 64'd1);
    check("lb_data", wb_data, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_err", {63'd0, wb_err}, 64'd0);

    // Crossing lhu: one hi_req pulse, in_ready low while waiting
    in_valid = 1'b1; sel = 4'b1010; addr_off = 3'd7; mem_data = 64'hAB00_0000_0000_0000;
    hi_data = 64'h0000_0000_0000_00CD; hi_valid = 1'b0;
    tick();
    in_valid = 1'b0;
    check("lhu_hi_req1", {63'd0, hi_req}, 64'd1);
    check("lhu_ready1", {63'd0, in_ready}, 64'd0);
    tick();
    check("lhu_hi_req2", {63'd0, hi_req}, 64'd0);
    check("lhu_ready2", {63'd0, in_ready}, 64'd0);
    hi_valid = 1'b1;
    tick();
    hi_valid = 1'b0;
    check("lhu_valid", {63'd0, wb_valid}, 64'd1);
    check("lhu_data", wb_data, 64'h0000_0000_0000_CDAB);

    // Back-to-back alu / pc / shift
    alu_out = 64'h1111_2222_3333_4444; pc = 64'h0000_0000_8000_1000;
    v_shift = 64'hDEAD_BEEF_0BAD_F00D; shift_out = v_shift;
    in_valid = 1'b1; sel = 4'b0000; tick();
    check("b2b_alu", wb_data, 64'h1111_2222_3333_4444);
    sel = 4'b0100; tick();
    check("b2b_pc", wb_data, 64'h0000_0000_8000_1000);
    sel = 4'b1100; tick();
    check("b2b_shift", wb_data, v_shift);

    // Consumer stall for three cycles
    v_alu = 64'h0123_4567_89AB_CDEF; alu_out = v_alu; sel = 4'b0000; wb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_ready", {63'd0, in_ready}, 64'd0);
      check("stall_data", wb_data, v_shift);
    end
    wb_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("stall_release", wb_data, v_alu);

    // Illegal select
    in_valid = 1'b1; sel = 4'b1111;
    tick();
    in_valid = 1'b0;
    check("illegal_err", {63'd0, wb_err}, 64'd1);
    check("illegal_data", wb_data, 64'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      sel       = 4'($urandom_range(0, 15));
      addr_off  = 3'($urandom_range(0, 7));
      mem_data  = {$urandom, $urandom};
      hi_data   = {$urandom, $urandom};
      alu_out   = {$urandom, $urandom};
      pc        = {$urandom, $urandom};
      shift_out = {$urandom, $urandom};
      wb_ready  = ($urandom_range(0, 3) != 0);
      hi_valid  = ($urandom_range(0, 1) != 0);
      tick();
    end
    in_valid = 1'b0; wb_ready = 1'b1; hi_valid = 1'b1;
    repeat (4) tick();

    // Reset while waiting for the second beat
    hi_valid = 1'b0; in_valid = 1'b1; sel = 4'b0101; addr_off = 3'd4;
    mem_data = {$urandom, $urandom};
    tick();
    in_valid = 1'b0;
    check("rstw_hi_req", {63'd0, hi_req}, 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rstw_valid", {63'd0, wb_valid}, 64'd0);
    check("rstw_data", wb_data, 64'd0);
    check("rstw_err", {63'd0, wb_err}, 64'd0);
    check("rstw_hi_req0", {63'd0, hi_req}, 64'd0);
    check("rstw_ready", {63'd0, in_ready}, 64'd1);
    hi_valid = 1'b1; hi_data = {$urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstw_hi_ignored", {63'd0, wb_valid}, 64'd0);
    end
    hi_valid = 1'b0;

    // MISALIGN_EN=0: crossing load is flagged, no second beat
    n_in_valid = 1'b1; n_sel = 4'b1010; n_off = 3'd7; n_mem = 64'hAB00_0000_0000_0000;
    tick();
    n_in_valid = 1'b0;
    check("nmis_hi_req", {63'd0, n_hi_req}, 64'd0);
    check("nmis_valid", {63'd0, n_wb_valid}, 64'd1);
    check("nmis_data", n_wb_data, 64'd0);
    check("nmis_err", {63'd0, n_wb_err}, 64'd1);
    n_in_valid = 1'b1; n_sel = 4'b1000; n_off = 3'd4; n_mem = 64'h8765_4321_0000_0000;
    tick();
    n_in_valid = 1'b0;
    check("nmis_lw", n_wb_data, 64'hFFFF_FFFF_8765_4321);
    check("nmis_lw_err", {63'd0, n_wb_err}, 64'd0);

    // XLEN=32: ld and lwu are illegal, lh still extracts
    c_in_valid = 1'b1; c_sel = 4'b0101; c_off = 2'd0; c_mem = 32'hFFFF_FFFF;
    tick();
    check("x32_ld_err", {63'd0, c_wb_err}, 64'd1);
    check("x32_ld_data", {32'd0, c_wb_data}, 64'd0);
    c_sel = 4'b1011;
    tick();
    check("x32_lwu_err", {63'd0, c_wb_err}, 64'd1);
    c_sel = 4'b0111; c_off = 2'd2; c_mem = 32'h8001_0000;
    tick();
    c_in_valid = 1'b0;
    check("x32_lh", {32'd0, c_wb_data}, 64'h0000_0000_FFFF_8001);
    check("x32_lh_err", {63'd0, c_wb_err}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
